// File: rtl/i2c_pkg.sv
// I2C master shared types: FSM states and quarter-phase indices.
// Imported by the bit timer and the transaction controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WACK,
    READ,
    RACK,
    STOP
  } state_t;

  typedef logic [1:0] qtr_t;

  localparam qtr_t Q0 = 2'd0;
  localparam qtr_t Q1 = 2'd1;
  localparam qtr_t Q2 = 2'd2;
  localparam qtr_t Q3 = 2'd3;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-phase timer for one I2C bit slot.
// Held at Q0/count 0 while hold is high (controller idle).
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  output qtr_t qtr,
  output logic tick,
  output logic slot_end
);

  localparam int CNT_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick     = (cnt == CNT_W'(CLK_DIV - 1));
  assign slot_end = tick && (qtr == Q3);

  always_ff @(posedge clk) begin
    if (reset || hold) begin
      cnt <= '0;
      qtr <= Q0;
    end else if (tick) begin
      cnt <= '0;
      qtr <= qtr + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C bus master: START, addr+R/W, 1..BYTES data bytes, STOP.
// Open-drain SDA; SCL is push-pull, no stretching or arbitration.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int BYTES   = 2,
  parameter int CW      = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               rw,
  input  logic [6:0]         addr,
  input  logic [CW-1:0]      nbytes,
  input  logic [8*BYTES-1:0] wdata,
  output logic [8*BYTES-1:0] rdata,
  output logic               busy,
  output logic               done,
  output logic               nack,
  output logic               scl,
  inout  wire                sda
);

  localparam int DW = 8 * BYTES;
  localparam int AW = $clog2(DW);

  state_t          state;
  state_t          state_nx;
  qtr_t            qtr;
  logic            tick;
  logic            slot_end;
  logic            sample;
  logic            accept;
  logic            byte_end;
  logic            last;
  logic            sda_low;
  logic            sda_smp;
  logic            rw_q;
  logic [2:0]      bit_cnt;
  logic [CW-1:0]   nb_in;
  logic [CW-1:0]   nb_q;
  logic [CW-1:0]   left;
  logic [CW-1:0]   byte_idx;
  logic [7:0]      sh;
  logic [DW-1:0]   wbuf;
  logic [AW-1:0]   rpos;

  i2c_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .hold    (state == IDLE),
    .qtr     (qtr),
    .tick    (tick),
    .slot_end(slot_end)
  );

  assign accept   = (state == IDLE) && start;
  assign sample   = tick && (qtr == Q2);
  assign byte_end = slot_end && (bit_cnt == 3'd7);
  assign last     = (left == CW'(1));
  assign byte_idx = nb_q - left;
  assign busy     = (state != IDLE);
  assign sda      = sda_low ? 1'b0 : 1'bz;

  // MSB-first bit position of the current read bit in rdata
  assign rpos = AW'(DW - 1 - 8 * int'(byte_idx)
                - int'(bit_cnt));

  always_comb begin
    nb_in = nbytes;
    if (nbytes == '0)
      nb_in = CW'(1);
    else if (nbytes > CW'(BYTES))
      nb_in = CW'(BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (accept) state_nx = START;
      START:    if (slot_end) state_nx = ADDR;
      ADDR:     if (byte_end) state_nx = ADDR_ACK;
      ADDR_ACK: if (slot_end)
                  state_nx = sda_smp ? STOP
                           : rw_q    ? READ : WRITE;
      WRITE:    if (byte_end) state_nx = WACK;
      WACK:     if (slot_end)
                  state_nx = (sda_smp || last) ? STOP
                                               : WRITE;
      READ:     if (byte_end) state_nx = RACK;
      RACK:     if (slot_end)
                  state_nx = last ? STOP : READ;
      STOP:     if (slot_end) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // SDA only moves at Q0 except the START/STOP edges
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    unique case (state)
      IDLE: ;
      START: sda_low = qtr[1];
      ADDR, WRITE: begin
        scl     = qtr[1];
        sda_low = !sh[7];
      end
      ADDR_ACK, WACK, READ: scl = qtr[1];
      RACK: begin
        scl     = qtr[1];
        sda_low = !last;
      end
      STOP: begin
        scl     = qtr[1];
        sda_low = (qtr != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q    <= 1'b0;
      nb_q    <= '0;
      left    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      wbuf    <= '0;
      rdata   <= '0;
      sda_smp <= 1'b1;
      nack    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        rw_q    <= rw;
        nb_q    <= nb_in;
        left    <= nb_in;
        bit_cnt <= '0;
        sh      <= {addr, rw};
        wbuf    <= wdata;
        rdata   <= '0;
        nack    <= 1'b0;
      end
      if (sample)
        sda_smp <= sda;
      if (sample && state == READ)
        rdata[rpos] <= sda;
      if (slot_end) begin
        unique case (state)
          ADDR, WRITE: begin
            sh      <= {sh[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          READ: bit_cnt <= bit_cnt + 3'd1;
          ADDR_ACK: begin
            if (sda_smp) begin
              nack <= 1'b1;
            end else begin
              sh   <= wbuf[DW-1 -: 8];
              wbuf <= wbuf << 8;
            end
          end
          WACK: begin
            left <= left - CW'(1);
            if (sda_smp) begin
              nack <= 1'b1;
            end else if (!last) begin
              sh   <= wbuf[DW-1 -: 8];
              wbuf <= wbuf << 8;
            end
          end
          RACK: left <= left - CW'(1);
          STOP: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level slave model, vector table,
// randomized transactions and reset/handshake corner cases.
module tb_i2c_master_ctrl;

  localparam int CLK_DIV = 2;
  localparam int BYTES   = 2;
  localparam int CW      = $clog2(BYTES + 1);
  localparam int DW      = 8 * BYTES;
  localparam int SLOT    = 4 * CLK_DIV;

  typedef struct {
    bit            rw;
    logic [6:0]    addr;
    logic [CW-1:0] nb;
    logic [DW-1:0] wd;
    bit            present;
    int            nack_at;
    logic [DW-1:0] rd;
    int            exp_cyc;
    bit            exp_nack;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [6:0]    addr = '0;
  logic [CW-1:0] nbytes = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          busy, done, nack, scl;
  wire           sda;

  int errors = 0;
  int checks = 0;

  pullup (sda);
  logic s_low = 1'b0;
  assign sda = s_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_ctrl #(
    .CLK_DIV(CLK_DIV),
    .BYTES  (BYTES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .nbytes(nbytes),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .nack  (nack),
    .scl   (scl),
    .sda   (sda)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ---------------- bus-level slave ----------------
  bit         sl_present;
  logic [6:0] sl_addr;
  int         sl_nack_at;
  logic [7:0] sl_rd [BYTES];
  logic [7:0] got [$];
  bit         mack [$];
  int         starts, stops, viol;
  logic       pscl = 1'b1;
  logic       psda = 1'b1;
  int         bitn, byte_no;
  logic [7:0] cur, tx;
  bit         is_rd, addr_ok, active;

  function automatic bit rd_ph();
    return is_rd && addr_ok && byte_no > 0;
  endfunction

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl;
    cd = sda;
    if (cd !== 1'b0 && cd !== 1'b1) viol++;
    if (cs && !pscl && cd != psda) viol++;
    if (pscl && cs && psda && !cd) begin
      starts++;
      active  = 1;
      bitn    = 0;
      byte_no = 0;
      s_low   = 1'b0;
    end else if (pscl && cs && !psda && cd) begin
      stops++;
      active = 0;
      s_low  = 1'b0;
    end else if (active && !pscl && cs) begin
      if (bitn < 8) begin
        if (!rd_ph()) cur = {cur[6:0], cd};
      end else if (rd_ph()) begin
        mack.push_back(cd);
      end
      bitn++;
    end else if (active && pscl && !cs) begin
      if (bitn == 8) begin
        if (rd_ph()) begin
          s_low = 1'b0;
        end else begin
          got.push_back(cur);
          if (byte_no == 0) begin
            is_rd   = cur[0];
            addr_ok = sl_present && cur[7:1] == sl_addr;
            s_low   = addr_ok;
          end else begin
            s_low = (byte_no != sl_nack_at);
          end
        end
      end else if (bitn == 9) begin
        bitn = 0;
        byte_no++;
        s_low = 1'b0;
        if (addr_ok && is_rd &&
            (byte_no == 1 || mack[$] == 1'b0)) begin
          tx    = sl_rd[byte_no-1];
          s_low = !tx[7];
        end
      end else if (bitn > 0 && rd_ph()) begin
        s_low = !tx[7-bitn];
      end
    end
    pscl = cs;
    psda = cd;
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_got [$];
  bit         exp_mack [$];

  task automatic model(input vec_t v, output int cyc,
                       output bit nk,
                       output logic [DW-1:0] rx);
    int n, k;
    n = (v.nb == 0) ? 1 : (v.nb > BYTES) ? BYTES : v.nb;
    exp_got.delete();
    exp_mack.delete();
    exp_got.push_back({v.addr, v.rw});
    rx = '0;
    nk = 0;
    if (!v.present) begin
      nk  = 1;
      cyc = (2 + 9) * SLOT;
    end else if (!v.rw) begin
      k = n;
      if (v.nack_at >= 1 && v.nack_at <= n) begin
        k  = v.nack_at;
        nk = 1;
      end
      for (int i = 0; i < k; i++)
        exp_got.push_back(v.wd[DW-1-8*i -: 8]);
      cyc = (2 + 9 * (1 + k)) * SLOT;
    end else begin
      for (int i = 0; i < n; i++) begin
        rx[DW-1-8*i -: 8] = v.rd[DW-1-8*i -: 8];
        exp_mack.push_back(i == n - 1);
      end
      cyc = (2 + 9 * (1 + n)) * SLOT;
    end
  endtask

  // ---------------- one transaction ----------------
  task automatic run(input vec_t v, input bit pre,
                     input int poke);
    int n, mc;
    bit bb, nk;
    logic [DW-1:0] rx;
    model(v, mc, nk, rx);
    if (!pre) @(negedge clk);
    sl_present = v.present;
    sl_addr    = v.addr;
    sl_nack_at = v.nack_at;
    for (int i = 0; i < BYTES; i++)
      sl_rd[i] = v.rd[DW-1-8*i -: 8];
    got.delete();
    mack.delete();
    starts = 0;
    stops  = 0;
    viol   = 0;
    rw     = v.rw;
    addr   = v.addr;
    nbytes = v.nb;
    wdata  = v.wd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    rw     = 1'($urandom);
    addr   = 7'($urandom);
    nbytes = CW'($urandom);
    wdata  = DW'($urandom);
    n  = 0;
    bb = 0;
    while (done !== 1'b1 && n < 4000) begin
      if (busy !== 1'b1) bb = 1;
      @(negedge clk);
      n++;
      start = (poke != 0 && n == poke);
    end
    start = 1'b0;
    chk("done_cycle", 64'(n), 64'(v.exp_cyc));
    chk("nack", 64'(nack), 64'(v.exp_nack));
    chk("rdata", 64'(rdata), 64'(v.exp_rdata));
    chk("busy_during", 64'(bb), 64'(0));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("starts", 64'(starts), 64'(1));
    chk("stops", 64'(stops), 64'(1));
    chk("bus_rules", 64'(viol), 64'(0));
    chk("nbytes_on_bus", 64'(got.size()),
        64'(exp_got.size()));
    for (int i = 0; i < got.size() &&
         i < exp_got.size(); i++)
      chk("bus_byte", 64'(got[i]), 64'(exp_got[i]));
    chk("n_master_acks", 64'(mack.size()),
        64'(exp_mack.size()));
    for (int i = 0; i < mack.size() &&
         i < exp_mack.size(); i++)
      chk("master_ack", 64'(mack[i]), 64'(exp_mack[i]));
  endtask

  vec_t tab [$];

  function automatic vec_t mk(
    bit r, logic [6:0] a, logic [CW-1:0] nb,
    logic [DW-1:0] wd, bit p, int na,
    logic [DW-1:0] rd, int ec, bit en,
    logic [DW-1:0] er);
    vec_t v;
    v.rw = r;  v.addr = a;  v.nb = nb;  v.wd = wd;
    v.present = p;  v.nack_at = na;  v.rd = rd;
    v.exp_cyc = ec;  v.exp_nack = en;
    v.exp_rdata = er;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   mc;
    bit   nk;
    logic [DW-1:0] rx;
    int   n;
    bit   saw;

    tab.push_back(mk(0, 7'h50, 2, 16'hA53C, 1, 0,
                     16'h0, 232, 0, 16'h0));
    tab.push_back(mk(1, 7'h50, 2, 16'h0, 1, 0,
                     16'h5AC3, 232, 0, 16'h5AC3));
    tab.push_back(mk(0, 7'h50, 2, 16'hA53C, 0, 0,
                     16'h0, 88, 1, 16'h0));
    tab.push_back(mk(0, 7'h50, 2, 16'hA53C, 1, 1,
                     16'h0, 160, 1, 16'h0));
    tab.push_back(mk(1, 7'h2B, 0, 16'h0, 1, 0,
                     16'h9E11, 160, 0, 16'h9E00));
    tab.push_back(mk(1, 7'h7F, 3, 16'h0, 1, 0,
                     16'h0FF0, 232, 0, 16'h0FF0));
    tab.push_back(mk(0, 7'h01, 2, 16'h8001, 1, 2,
                     16'h0, 232, 1, 16'h0));
    tab.push_back(mk(1, 7'h50, 1, 16'h0, 0, 0,
                     16'h1234, 88, 1, 16'h0));
    for (int i = 0; i < 12; i++) begin
      v.rw      = 1'($urandom);
      v.addr    = 7'($urandom);
      v.nb      = CW'($urandom_range(0, 3));
      v.wd      = DW'($urandom);
      v.present = ($urandom_range(0, 4) != 0);
      v.nack_at = $urandom_range(0, 3);
      v.rd      = DW'($urandom);
      model(v, mc, nk, rx);
      v.exp_cyc   = mc;
      v.exp_nack  = nk;
      v.exp_rdata = rx;
      tab.push_back(v);
    end

    repeat (3) @(negedge clk);
    chk("rst_scl", 64'(scl), 64'(1));
    chk("rst_sda", 64'(sda), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_nack", 64'(nack), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    reset = 1'b0;

    // first run pokes start while busy, second starts
    // on the done cycle
    run(tab[0], 0, 40);
    run(tab[1], 1, 0);
    for (int i = 2; i < tab.size(); i++)
      run(tab[i], 0, 0);

    // reset in the middle of the address byte
    @(negedge clk);
    rw = 0;  addr = 7'h50;  nbytes = 2;
    wdata = 16'hA53C;  start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_scl", 64'(scl), 64'(1));
    chk("abort_sda", 64'(sda), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    saw = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1;
    end
    chk("abort_no_done", 64'(saw), 64'(0));
    run(tab[0], 0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Parametrised I2C bus master that runs a complete transaction: START, 7-bit address plus R/W, 1..BYTES data bytes with ACK handling, then STOP. It replaces the fixed-width `i2c_master` read path and has the following additions:
- configurable SCL rate and byte count
- write and read modes
- slave-NACK detection
- a start/busy/done handshake toward the host logic

It sits between on-chip control logic and the open-drain SCL/SDA pads.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period (SCL = f_clk / (4*CLK_DIV)); legal range ≥1.
- BYTES, 2: maximum bytes per transaction, 1..4.
- CW, $clog2(BYTES+1): width of byte-count port.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted on a rising clk edge when start=1 and busy=0.
- rw  input  1  0 = write, 1 = read; sampled at accept.
- addr  input  7  slave address; sampled at accept.
- nbytes  input  CW  byte count 1..BYTES; sampled at accept. Values 0 or >BYTES are clamped to 1 or BYTES respectively.
- wdata  input  8*BYTES  write payload; byte 0 = wdata[8*BYTES-1 -: 8]; sampled at accept.
- rdata  output  8*BYTES  read payload, same byte order; unread bytes 0.
- busy  output  1  high from cycle after accept until done.
- done  output  1  one-cycle pulse at transaction end.
- nack  output  1  valid with done; 1 = slave NACKed address or a write byte.
- scl  output  1  SCL level (1 = released/high).
- sda  inout  1  open-drain: driven 0 or 1'bz, never driven 1; external pull-up.

## Operation
- Reset values:
  - scl=1, sda released, busy=0, done=0, nack=0, rdata=0.
  - FSM IDLE, phase counter 0.
- Reset asserted mid-transaction: the next edge aborts to the reset values. No STOP is generated and done is not pulsed.
- Bit timing: each bit slot is 4 quarters of CLK_DIV cycles (Q0..Q3).
  - SCL is low in Q0/Q1 and high in Q2/Q3.
  - The master changes SDA only at the start of Q0.
  - The master samples SDA on the last cycle of Q2.
- FSM states:
  - IDLE → START: on accept; rdata is cleared to 0 at accept.
  - START (1 slot): SDA released in Q0/Q1 with SCL held high; SDA pulled low at Q2; SCL low after Q3.
  - ADDR (8 slots): {addr, rw} MSB first.
  - ADDR_ACK (1 slot): SDA released, then sampled. A sampled 1 sets nack and goes to STOP. A sampled 0 goes to WRITE if rw=0, else READ.
  - WRITE (8 slots) → WACK (1 slot, sampled). A NACK sets nack and goes to STOP. An ACK on the last byte goes to STOP; otherwise the next byte goes to WRITE.
  - READ (8 slots, SDA released; shift sampled bits into the current byte MSB first) → RACK (1 slot). The master drives 0 (ACK) except on the last byte, where it releases (NACK). Then READ, or STOP after the last byte.
  - STOP (1 slot): SDA low in Q0/Q1, SCL high at Q2, SDA released at Q3.
  - STOP → IDLE with a done pulse on the cycle after the slot ends; busy falls the same cycle.
- start while busy=1 is ignored (not queued).
- Clock stretching and arbitration are not supported; a slave holding SCL low is not observed.
- A byte counter decrements per completed byte; byte index wraps never (bounded by nbytes).

## Timing
- Slot = 4*CLK_DIV cycles.
- Successful transaction of n bytes: done asserts (2 + 9*(1+n)) * 4*CLK_DIV cycles after the accept edge.
- Address NACK: done at (2 + 9) slots after accept.
- Write-byte-k NACK (k from 1): done at (2 + 9*(1+k)) slots after accept.
- busy is high for exactly the same count of cycles; a new start is accepted the cycle after done.
- rdata is updated per bit and is stable from done until the next accept.

## Structure
- Package i2c_pkg:
  - FSM state enum (IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, RACK, STOP)
  - quarter-phase constants Q0..Q3
- Sub-module i2c_bit_timer (params CLK_DIV) provides:
  - quarter-phase counter, emitting quarter index and a one-cycle `tick` at each quarter end
  - slot-end strobe
  - held in reset when FSM is IDLE
- Top holds the FSM, bit/byte counters, shift registers, SDA output-enable.

## Test plan
All scenarios use CLK_DIV=2, BYTES=2, a behavioural slave model and a pull-up.
- Write 2 bytes: addr=0x50, wdata=0xA53C, slave ACKs all → SDA shows 0xA0, 0xA5, 0x3C; done at cycle 232 after accept; nack=0.
- Read 2 bytes: addr=0x50, slave returns 0x5A, 0xC3 → rdata=0x5AC3; master ACKs byte 1 and NACKs byte 2; done at 232.
- Address NACK: slave absent (SDA pulled high) → STOP issued; nack=1; done at cycle 88; no data slots.
- NACK on write byte 1 of 2 → nack=1, done at 160, byte 2 never sent.
- start pulsed while busy, plus a second start the cycle after done → first ignored (busy unchanged), second accepted.
- reset asserted mid-ADDR → next cycle scl=1, sda=Z, busy=0, no done pulse; next start then runs normally.
- All scenarios: SDA is never driven 1, and SDA changes only while SCL=0 except at START/STOP.
